// File: rtl/lc3_mem_pkg.sv
// ----------------------------------------------------------------------------
// lc3_mem_pkg
// Types and constants shared by the LC3 memory-port arbiter and its
// round-robin picker.
//   DATA_WIDTH : width of an LC3 memory word
//   state_t    : access FSM states
// ----------------------------------------------------------------------------
package lc3_mem_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,  // waiting for a request
        ISSUE   = 2'd1,  // access on the memory port, gnt pulse
        RD_WAIT = 2'd2,  // waiting out the memory read latency
        RD_DONE = 2'd3   // rdata valid, rvalid pulse
    } state_t;

endpackage

// File: rtl/lc3_rr_arbiter.sv
// ----------------------------------------------------------------------------
// lc3_rr_arbiter
// Combinational rotate-priority picker. The search starts at the requester
// just after the previous winner and wraps modulo NUM_REQ, so every requester
// waits at most NUM_REQ-1 grants.
// Ports:
//   req        in   NUM_REQ  request vector
//   last_gnt   in   IDX_W    index of the previous winner
//   valid      out  1        at least one request present
//   winner     out  NUM_REQ  one-hot winner (zero when no request)
//   winner_idx out  IDX_W    binary index of the winner
// ----------------------------------------------------------------------------
module lc3_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic               valid,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every output of this block gets a default before the loop;
        // a path that skips an assignment would otherwise infer a latch.
        valid      = 1'b0;
        winner     = '0;
        winner_idx = '0;
        cand       = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(last_gnt) + off) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                winner[cand] = 1'b1;
                winner_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// ----------------------------------------------------------------------------
// lc3_mem_arbiter
// Shares one LC3 memory port between NUM_REQ requesters (core = 0, loader or
// DMA = 1, ...). One access is in flight at a time; read data comes back
// READ_LATENCY cycles after the address is presented and is held in rdata
// until the next read completes.
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   req, we          per-requester request and write flag
//   addr, wdata      per-requester address / write data, packed by index
//   gnt              one-hot pulse in the cycle the access is on the port
//   rvalid, rdata    one-hot read-complete pulse and captured read data
//   busy             FSM not idle
//   mar, mdr, memwe  memory address, write data, write enable
//   memOut           memory read data
// ----------------------------------------------------------------------------
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int ADDRESS_WIDTH = 16,
    parameter int READ_LATENCY  = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               we,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             busy,
    output logic [ADDRESS_WIDTH-1:0]         mar,
    output logic [DATA_WIDTH-1:0]            mdr,
    output logic                             memwe,
    input  logic [DATA_WIDTH-1:0]            memOut
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // Counter only needs to reach READ_LATENCY-1; keep at least one bit.
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     last_gnt;
    logic [NUM_REQ-1:0]   cur_gnt;     // one-hot owner of the access in flight
    logic [CNT_W-1:0]     lat_cnt;

    logic                 pick_valid;
    logic [NUM_REQ-1:0]   pick;
    logic [IDX_W-1:0]     pick_idx;

    lc3_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req),
        .last_gnt   (last_gnt),
        .valid      (pick_valid),
        .winner     (pick),
        .winner_idx (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = ISSUE;
            // memwe already holds the winner's we flag during ISSUE.
            ISSUE:   state_next = memwe ? IDLE : RD_WAIT;
            RD_WAIT: if (lat_cnt == '0) state_next = RD_DONE;
            RD_DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mar      <= '0;
            mdr      <= '0;
            memwe    <= 1'b0;
            rdata    <= '0;
            cur_gnt  <= '0;
            lat_cnt  <= '0;
            last_gnt <= IDX_W'(NUM_REQ - 1);  // requester 0 wins first
        end else begin
            case (state)
                IDLE: begin
                    // Requests are only looked at here; outside IDLE they are ignored.
                    if (pick_valid) begin
                        mar      <= addr[pick_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        mdr      <= wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                        memwe    <= we[pick_idx];
                        last_gnt <= pick_idx;
                        cur_gnt  <= pick;
                    end
                end
                ISSUE: begin
                    memwe   <= 1'b0;
                    lat_cnt <= CNT_W'(READ_LATENCY - 1);
                end
                RD_WAIT: begin
                    if (lat_cnt == '0) rdata   <= memOut;
                    else               lat_cnt <= lat_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign gnt    = (state == ISSUE)   ? cur_gnt : '0;
    assign rvalid = (state == RD_DONE) ? cur_gnt : '0;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_lc3_mem_arbiter
// Two arbiter instances with their own memory models: dut1 (READ_LATENCY=1)
// driven from a vector table with a grant/read scoreboard, and dut3
// (READ_LATENCY=3) driven by hand-written sequences for latency, reset in
// RD_WAIT and priority after reset.
// ----------------------------------------------------------------------------
module tb_lc3_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- dut1: READ_LATENCY = 1 ----------------
    logic [1:0]  req1 = '0, we1 = '0;
    logic [31:0] addr1 = '0, wdata1 = '0;
    logic [1:0]  gnt1, rvalid1;
    logic [15:0] rdata1, mar1, mdr1, mem_out1;
    logic        busy1, memwe1;
    logic [15:0] mem1 [0:65535];

    lc3_mem_arbiter #(.NUM_REQ(2), .ADDRESS_WIDTH(16), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1), .busy(busy1),
        .mar(mar1), .mdr(mdr1), .memwe(memwe1), .memOut(mem_out1)
    );

    always @(posedge clk) begin
        if (memwe1) mem1[mar1] <= mdr1;
        mem_out1 <= mem1[mar1];
    end

    // ---------------- dut3: READ_LATENCY = 3 ----------------
    logic [1:0]  req3 = '0, we3 = '0;
    logic [31:0] addr3 = '0, wdata3 = '0;
    logic [1:0]  gnt3, rvalid3;
    logic [15:0] rdata3, mar3, mdr3, mem_out3, pipe0, pipe1;
    logic        busy3, memwe3;
    logic [15:0] mem3 [0:65535];

    lc3_mem_arbiter #(.NUM_REQ(2), .ADDRESS_WIDTH(16), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
        .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .busy(busy3),
        .mar(mar3), .mdr(mdr3), .memwe(memwe3), .memOut(mem_out3)
    );

    always @(posedge clk) begin
        if (memwe3) mem3[mar3] <= mdr3;
        pipe0    <= mem3[mar3];
        pipe1    <= pipe0;
        mem_out3 <= pipe1;
    end

    // ---------------- dut1 scoreboard ----------------
    typedef struct { int idx; logic w; logic [15:0] a; logic [15:0] d; } gnt_exp_t;
    typedef struct { int idx; logic [15:0] d; } rd_exp_t;
    gnt_exp_t gq[$];
    rd_exp_t  rq[$];
    int       rd_gnt_cyc = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (gnt1 != '0 || rvalid1 != '0)
                check("strobe_onehot", $countones({gnt1, rvalid1}), 1);
            if (memwe1 && gnt1 == '0)
                check("memwe_outside_issue", 32'(memwe1), 0);
            if (gnt1 != '0) begin
                if (gq.size() == 0) begin
                    check("unexpected_gnt", 32'(gnt1), 0);
                end else begin
                    gnt_exp_t e;
                    e = gq.pop_front();
                    check("sb_gnt", 32'(gnt1), 32'(1 << e.idx));
                    check("sb_memwe", 32'(memwe1), 32'(e.w));
                    check("sb_mar", 32'(mar1), 32'(e.a));
                    if (e.w) check("sb_mdr", 32'(mdr1), 32'(e.d));
                    else     rd_gnt_cyc = cyc;
                end
            end
            if (rvalid1 != '0) begin
                if (rq.size() == 0) begin
                    check("unexpected_rvalid", 32'(rvalid1), 0);
                end else begin
                    rd_exp_t r;
                    r = rq.pop_front();
                    check("sb_rvalid", 32'(rvalid1), 32'(1 << r.idx));
                    check("sb_rdata", 32'(rdata1), 32'(r.d));
                    check("sb_rd_latency", cyc - rd_gnt_cyc, 2);
                end
            end
        end
    end

    // Single access on dut1: drive, expect gnt one cycle later, then idle
    // after 1 cycle (write) or 3 cycles (read, latency 1).
    task automatic access1(input int idx, input logic w, input logic [15:0] a,
                           input logic [15:0] d, input logic [15:0] exp_rd, input string tag);
        int waited;
        we1[idx] = w;
        addr1[idx*16 +: 16]  = a;
        wdata1[idx*16 +: 16] = d;
        req1[idx] = 1'b1;
        gq.push_back('{idx, w, a, d});
        if (!w) rq.push_back('{idx, exp_rd});
        waited = 0;
        do begin @(negedge clk); waited++; end while (gnt1[idx] !== 1'b1 && waited < 20);
        check({tag, "_gnt_latency"}, waited, 1);
        req1[idx] = 1'b0;
        waited = 0;
        do begin @(negedge clk); waited++; end while (busy1 && waited < 20);
        check({tag, "_cycles_to_idle"}, waited, w ? 1 : 3);
    endtask

    // ---------------- dut3 helpers ----------------
    task automatic wait_gnt3(output int waited);
        waited = 0;
        do begin @(negedge clk); waited++; end while (gnt3 == '0 && waited < 20);
    endtask

    task automatic wait_rvalid3(output int waited);
        waited = 0;
        do begin @(negedge clk); waited++; end while (rvalid3 == '0 && waited < 20);
    endtask

    task automatic access3(input int idx, input logic w, input logic [15:0] a,
                           input logic [15:0] d, input logic [15:0] exp_rd, input string tag);
        int waited;
        we3[idx] = w;
        addr3[idx*16 +: 16]  = a;
        wdata3[idx*16 +: 16] = d;
        req3[idx] = 1'b1;
        wait_gnt3(waited);
        check({tag, "_gnt_latency"}, waited, 1);
        check({tag, "_gnt"}, 32'(gnt3), 32'(1 << idx));
        check({tag, "_memwe"}, 32'(memwe3), 32'(w));
        check({tag, "_mar"}, 32'(mar3), 32'(a));
        if (w) check({tag, "_mdr"}, 32'(mdr3), 32'(d));
        req3[idx] = 1'b0;
        if (!w) begin
            wait_rvalid3(waited);
            check({tag, "_rd_latency"}, waited, 4);
            check({tag, "_rvalid"}, 32'(rvalid3), 32'(1 << idx));
            check({tag, "_rdata"}, 32'(rdata3), 32'(exp_rd));
        end
        waited = 0;
        do begin @(negedge clk); waited++; end while (busy3 && waited < 20);
        check({tag, "_idle"}, 32'(busy3), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct { int idx; logic w; logic [15:0] a; logic [15:0] d; logic [15:0] exp_rd; } vec_t;
    localparam int NV = 7;
    vec_t vecs [NV];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int first;
        int g;
        int seen;
        int waited;

        vecs[0] = '{0, 1'b1, 16'h3000, 16'h1234, 16'h0000};
        vecs[1] = '{1, 1'b0, 16'h3000, 16'h0000, 16'h1234};
        vecs[2] = '{1, 1'b1, 16'h4001, 16'hBEEF, 16'h0000};
        vecs[3] = '{0, 1'b0, 16'h4001, 16'h0000, 16'hBEEF};
        vecs[4] = '{0, 1'b1, 16'hFFFF, 16'hA5A5, 16'h0000};
        vecs[5] = '{1, 1'b0, 16'hFFFF, 16'h0000, 16'hA5A5};
        vecs[6] = '{0, 1'b0, 16'h3000, 16'h0000, 16'h1234};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt1), 0);
        check("rst_rvalid", 32'(rvalid1), 0);
        check("rst_busy", 32'(busy1), 0);
        check("rst_memwe", 32'(memwe1), 0);
        check("rst_mar", 32'(mar1), 0);
        check("rst_rdata", 32'(rdata1), 0);
        reset = 1'b0;
        @(negedge clk);

        // Single-requester writes and reads through the table
        for (int i = 0; i < NV; i++)
            access1(vecs[i].idx, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd,
                    $sformatf("vec%0d", i));

        // Both requesters held with writes: alternating grants every 2 cycles
        first = (vecs[NV-1].idx + 1) % 2;
        we1 = 2'b11;
        addr1  = {16'h5001, 16'h5000};
        wdata1 = {16'h2222, 16'h1111};
        for (int j = 0; j < 6; j++) begin
            g = (first + j) % 2;
            gq.push_back('{g, 1'b1, g ? 16'h5001 : 16'h5000, g ? 16'h2222 : 16'h1111});
        end
        req1 = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k % 2 == 1) check("rr_gnt", 32'(gnt1), 32'(1 << ((first + (k - 1) / 2) % 2)));
            else            check("rr_gap", 32'(gnt1), 0);
        end
        req1 = 2'b00;
        repeat (2) @(negedge clk);

        // req[1] pulsed while req[0] read is in flight: ignored
        we1 = 2'b00;
        addr1 = {16'h4001, 16'h3000};
        gq.push_back('{0, 1'b0, 16'h3000, 16'h0000});
        rq.push_back('{0, 16'h1234});
        req1[0] = 1'b1;
        @(negedge clk);
        check("pulse_gnt0", 32'(gnt1), 1);
        req1[0] = 1'b0;
        req1[1] = 1'b1;
        @(negedge clk);
        req1[1] = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (gnt1[1]) seen++;
        end
        check("pulse_ignored", seen, 0);

        // Reset during a read on dut1: everything clears immediately
        wdata1[15:0] = 16'h5A5A;
        addr1[15:0]  = 16'h4001;
        gq.push_back('{0, 1'b0, 16'h4001, 16'h0000});
        req1[0] = 1'b1;
        @(negedge clk);
        req1[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_gnt", 32'(gnt1), 0);
        check("midrst_rvalid", 32'(rvalid1), 0);
        check("midrst_memwe", 32'(memwe1), 0);
        check("midrst_busy", 32'(busy1), 0);
        check("midrst_mar", 32'(mar1), 0);
        check("midrst_mdr", 32'(mdr1), 0);
        check("midrst_rdata", 32'(rdata1), 0);
        gq.delete();
        rq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // dut3: write then read with READ_LATENCY = 3
        access3(0, 1'b1, 16'h3000, 16'h1234, 16'h0000, "l3_wr");
        access3(1, 1'b0, 16'h3000, 16'h0000, 16'h1234, "l3_rd");

        // dut3: reset during RD_WAIT discards the pending read
        we3 = 2'b00;
        addr3[15:0] = 16'h3000;
        req3[0] = 1'b1;
        @(negedge clk);
        check("l3_rst_gnt", 32'(gnt3), 1);
        req3[0] = 1'b0;
        @(negedge clk);
        check("l3_rst_in_wait", 32'(busy3), 1);
        reset = 1'b1;
        #1;
        check("l3_rst_busy", 32'(busy3), 0);
        check("l3_rst_gnt0", 32'(gnt3), 0);
        check("l3_rst_rvalid0", 32'(rvalid3), 0);
        check("l3_rst_mar", 32'(mar3), 0);
        check("l3_rst_mdr", 32'(mdr3), 0);
        check("l3_rst_rdata", 32'(rdata3), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid3 != '0) seen++;
        end
        check("l3_rst_no_rvalid", seen, 0);

        // dut3: simultaneous requests after reset -> req 0 first, then req 1 read
        we3    = 2'b01;
        addr3  = {16'h3000, 16'h3100};
        wdata3 = {16'h0000, 16'h7777};
        req3   = 2'b11;
        wait_gnt3(waited);
        check("l3_prio_latency", waited, 1);
        check("l3_prio_gnt0", 32'(gnt3), 1);
        check("l3_prio_memwe", 32'(memwe3), 1);
        req3[0] = 1'b0;
        wait_gnt3(waited);
        check("l3_second_latency", waited, 2);
        check("l3_second_gnt1", 32'(gnt3), 2);
        check("l3_second_memwe", 32'(memwe3), 0);
        check("l3_second_mar", 32'(mar3), 32'h3000);
        req3[1] = 1'b0;
        wait_rvalid3(waited);
        check("l3_second_rd_latency", waited, 4);
        check("l3_second_rvalid", 32'(rvalid3), 2);
        check("l3_second_rdata", 32'(rdata3), 32'h1234);
        repeat (3) @(negedge clk);

        check("sb_gnt_drained", gq.size(), 0);
        check("sb_rd_drained", rq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
